dmem_resp: RTL and testbench

Data-memory responder for the core's load/store path. It accepts store requests (byte-enable mask, address, right-aligned data) from the execute stage and aligns them onto 32-bit memory words. Stores pass through a one-entry posted write buffer. Loads get same-cycle, right-aligned read data with buffer forwarding, so the execute stage can sign- or zero-extend from bit 0.

---
 rtl/dmem_resp.sv | 118 +++++++++++
 tb/tb_dmem_resp.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/dmem_resp.sv
// Data-memory responder: aligned stores through a one-entry posted write buffer, forwarded loads.
// Define DMEM_ERR_EN to reject misaligned stores and report them on err_o/err_addr_o.
module dmem_resp #(
    parameter int unsigned ADDR_WIDTH = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  mem_wen_i,
    input  logic [31:0] mem_waddr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [31:0] mem_raddr_i,
    output logic [31:0] mem_rdata_o,
    output logic        err_o,
    output logic [31:0] err_addr_o,
    input  logic        err_clr_i
);

    localparam int unsigned Depth = 2 ** ADDR_WIDTH;

    logic [31:0]           r_mem [Depth];

    logic                  r_wb_valid;
    logic [ADDR_WIDTH-1:0] r_wb_idx;
    logic [3:0]            r_wb_mask;
    logic [31:0]           r_wb_data;

    logic [1:0]            w_woff;
    logic [7:0]            w_mask_wide;
    logic [3:0]            w_lane_mask;
    logic [31:0]           w_lane_data;
    logic                  w_misaligned;
    logic                  w_accept;
    logic [ADDR_WIDTH-1:0] w_widx;
    logic [ADDR_WIDTH-1:0] w_ridx;
    logic [31:0]           w_rword;
    logic                  w_unused;

    assign w_woff       = mem_waddr_i[1:0];
    assign w_widx       = mem_waddr_i[ADDR_WIDTH+1:2];
    assign w_ridx       = mem_raddr_i[ADDR_WIDTH+1:2];
    // Widened shift so lanes pushed past byte 3 are visible for the misalignment check
    assign w_mask_wide  = {4'b0000, mem_wen_i} << w_woff;
    assign w_lane_mask  = w_mask_wide[3:0];
    assign w_misaligned = |w_mask_wide[7:4];
    assign w_lane_data  = mem_wdata_i << {w_woff, 3'b000};

`ifdef DMEM_ERR_EN
    logic        r_err;
    logic [31:0] r_err_addr;

    assign w_accept = (|w_lane_mask) && !w_misaligned;

    // A clear on the same edge as a new misaligned store lets the new address in
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err      <= 1'b0;
            r_err_addr <= '0;
        end else if (w_misaligned && (!r_err || err_clr_i)) begin
            r_err      <= 1'b1;
            r_err_addr <= mem_waddr_i;
        end else if (err_clr_i) begin
            r_err      <= 1'b0;
            r_err_addr <= '0;
        end
    end

    assign err_o      = r_err;
    assign err_addr_o = r_err_addr;
    assign w_unused   = ^{mem_waddr_i[31:ADDR_WIDTH+2], mem_raddr_i[31:ADDR_WIDTH+2]};
`else
    assign w_accept   = |w_lane_mask;
    assign err_o      = 1'b0;
    assign err_addr_o = '0;
    assign w_unused   = ^{err_clr_i, w_misaligned, mem_waddr_i[31:ADDR_WIDTH+2],
                          mem_raddr_i[31:ADDR_WIDTH+2]};
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wb_valid <= 1'b0;
            r_wb_idx   <= '0;
            r_wb_mask  <= '0;
            r_wb_data  <= '0;
        end else begin
            r_wb_valid <= w_accept;
            if (w_accept) begin
                r_wb_idx  <= w_widx;
                r_wb_mask <= w_lane_mask;
                r_wb_data <= w_lane_data;
            end
        end
    end

    // Array is deliberately not reset; a reset discards the buffer before it can commit
    always_ff @(posedge clk) begin
        if (r_wb_valid) begin
            for (int b = 0; b < 4; b++) begin
                if (r_wb_mask[b]) begin
                    r_mem[r_wb_idx][8*b +: 8] <= r_wb_data[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        w_rword = r_mem[w_ridx];
        if (r_wb_valid && (r_wb_idx == w_ridx)) begin
            for (int b = 0; b < 4; b++) begin
                if (r_wb_mask[b]) begin
                    w_rword[8*b +: 8] = r_wb_data[8*b +: 8];
                end
            end
        end
    end

    assign mem_rdata_o = w_rword >> {mem_raddr_i[1:0], 3'b000};

endmodule

// File: tb/tb_dmem_resp.sv
// Self-checking bench for dmem_resp: expected load data is queued at issue and popped on compare.
module tb_dmem_resp;

    logic        clk;
    logic        rst;
    logic [3:0]  mem_wen_i;
    logic [31:0] mem_waddr_i;
    logic [31:0] mem_wdata_i;
    logic [31:0] mem_raddr_i;
    logic [31:0] mem_rdata_o;
    logic        err_o;
    logic [31:0] err_addr_o;
    logic        err_clr_i;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    dmem_resp #(.ADDR_WIDTH(12)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .mem_wen_i   (mem_wen_i),
        .mem_waddr_i (mem_waddr_i),
        .mem_wdata_i (mem_wdata_i),
        .mem_raddr_i (mem_raddr_i),
        .mem_rdata_o (mem_rdata_o),
        .err_o       (err_o),
        .err_addr_o  (err_addr_o),
        .err_clr_i   (err_clr_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Store is presented for exactly one rising edge
    task automatic store(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] data);
        mem_wen_i   = wen;
        mem_waddr_i = addr;
        mem_wdata_i = data;
        tick();
        mem_wen_i   = 4'b0000;
    endtask

    task automatic load(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] e;
        string       t;
        mem_raddr_i = addr;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        #2;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check(t, mem_rdata_o, e);
    endtask

    initial begin
        rst         = 1'b0;
        mem_wen_i   = 4'b0000;
        mem_waddr_i = '0;
        mem_wdata_i = '0;
        mem_raddr_i = '0;
        err_clr_i   = 1'b0;
        idle(3);
        check("rst_err", {31'b0, err_o}, 32'h0);
        check("rst_err_addr", err_addr_o, 32'h0);
        rst = 1'b1;
        idle(1);

        // Forwarding then array
        store(4'b1111, 32'h100, 32'hDEADBEEF);
        load("sw_fwd", 32'h100, 32'hDEADBEEF);
        idle(2);
        load("sw_array", 32'h100, 32'hDEADBEEF);

        // Byte merge into preloaded word
        store(4'b1111, 32'h100, 32'h11223344);
        idle(2);
        store(4'b0001, 32'h102, 32'h000000AA);
        load("sb_fwd_w", 32'h100, 32'h11AA3344);
        load("sb_fwd_off2", 32'h102, 32'h000011AA);
        idle(2);
        load("sb_array_w", 32'h100, 32'h11AA3344);
        load("sb_array_off3", 32'h103, 32'h00000011);

        // Back-to-back halfwords
        store(4'b0011, 32'h200, 32'h0000BEEF);
        store(4'b0011, 32'h202, 32'h0000CAFE);
        load("sh_b2b", 32'h200, 32'hCAFEBEEF);
        load("sh_b2b_off1", 32'h201, 32'h00CAFEBE);
        idle(2);
        load("sh_b2b_array", 32'h200, 32'hCAFEBEEF);

        // Misaligned stores
        store(4'b1111, 32'h300, 32'h01020304);
        store(4'b1111, 32'h304, 32'h05060708);
        idle(2);
`ifdef DMEM_ERR_EN
        store(4'b1111, 32'h301, 32'hFFFFFFFF);
        check("err_set", {31'b0, err_o}, 32'h1);
        store(4'b0011, 32'h307, 32'h0000FFFF);
        idle(2);
        check("err_sticky", {31'b0, err_o}, 32'h1);
        check("err_addr_first", err_addr_o, 32'h301);
        load("mis_w300", 32'h300, 32'h01020304);
        load("mis_w304", 32'h304, 32'h05060708);
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
        check("err_clr", {31'b0, err_o}, 32'h0);
        check("err_clr_addr", err_addr_o, 32'h0);
        store(4'b1111, 32'h302, 32'h0);
        err_clr_i = 1'b1;
        store(4'b1111, 32'h303, 32'h0);
        err_clr_i = 1'b0;
        check("clr_set_err", {31'b0, err_o}, 32'h1);
        check("clr_set_addr", err_addr_o, 32'h303);
`else
        store(4'b0011, 32'h307, 32'h0000BEEF);
        idle(2);
        load("mis_sh_w304", 32'h304, 32'hEF060708);
        load("mis_sh_b307", 32'h307, 32'h000000EF);
        store(4'b1111, 32'h301, 32'hAABBCCDD);
        idle(2);
        load("mis_sw_w300", 32'h300, 32'hBBCCDD04);
        err_clr_i = 1'b1;
        tick();
        err_clr_i = 1'b0;
        check("noerr_flag", {31'b0, err_o}, 32'h0);
        check("noerr_addr", err_addr_o, 32'h0);
`endif

        // Reset discards a pending buffered store
        store(4'b1111, 32'h400, 32'hA5A5A5A5);
        idle(2);
        store(4'b1111, 32'h400, 32'h12345678);
        rst = 1'b0;
        idle(2);
        rst = 1'b1;
        idle(1);
        load("rst_drop", 32'h400, 32'hA5A5A5A5);
        idle(2);
        load("rst_drop_late", 32'h400, 32'hA5A5A5A5);

        // Address wrap
        store(4'b1111, 32'h4000, 32'hCAFEF00D);
        idle(2);
        load("wrap_w0", 32'h0, 32'hCAFEF00D);
        load("wrap_alias", 32'h4002, 32'h0000CAFE);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
